// File: rtl/conv2_buf_pkg.sv
// Shared CNN parameters for the conv2 stage (buffer and calculator blocks).
// Contents: default feature-map geometry, window size, pixel width and a
// counter-width helper.
package conv2_buf_pkg;

    localparam int unsigned CNN_IMG_W = 12;
    localparam int unsigned CNN_IMG_H = 12;
    localparam int unsigned CNN_K     = 5;
    localparam int unsigned CNN_DW    = 12;

    // Width of a counter/index covering 0..n-1 (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2_buf_if.sv
// Pixel-in / window-out bus of the conv2 line buffer.
// Signals: valid_in, data_in1..3 (one pixel per channel, raster order);
// data_outC_0..24 (5x5 window per channel, index r*5+c), valid_out_buf.
// Modports: master = pixel source / window sink, slave = conv2_buf.
interface conv2_buf_if
    import conv2_buf_pkg::*;
#(
    parameter int unsigned DW = CNN_DW
) ();

    logic                 valid_in;
    logic signed [DW-1:0] data_in1, data_in2, data_in3;
    logic                 valid_out_buf;

    logic signed [DW-1:0] data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
                          data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
                          data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
                          data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
                          data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24;
    logic signed [DW-1:0] data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
                          data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
                          data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
                          data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
                          data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24;
    logic signed [DW-1:0] data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
                          data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
                          data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
                          data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
                          data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24;

    modport master (
        output valid_in, data_in1, data_in2, data_in3,
        input  valid_out_buf,
        input  data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
               data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
               data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
               data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
               data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
        input  data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
               data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
               data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
               data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
               data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
        input  data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
               data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
               data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
               data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
               data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24
    );

    modport slave (
        input  valid_in, data_in1, data_in2, data_in3,
        output valid_out_buf,
        output data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
               data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
               data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
               data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
               data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
        output data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
               data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
               data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
               data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
               data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
        output data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
               data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
               data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
               data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
               data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24
    );

endinterface

// File: rtl/conv2_buf_ch.sv
// One channel of the conv2 line buffer: K-1 line memories plus a KxK
// register window that shifts one column left per accepted pixel.
// Ports: clk, rst (sync, active-high, clears the window only), shift_en
// (accept this pixel), col_i (current column), pix_i (incoming pixel),
// win_o (window, index r*K+c, r=0 oldest row, c=K-1 newest column).
module conv2_buf_ch
    import conv2_buf_pkg::*;
#(
    parameter  int unsigned IMG_W = CNN_IMG_W,
    parameter  int unsigned K     = CNN_K,
    parameter  int unsigned DW    = CNN_DW,
    localparam int unsigned COL_W = idx_w(IMG_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [COL_W-1:0]     col_i,
    input  logic signed [DW-1:0] pix_i,
    output logic signed [DW-1:0] win_o [K*K]
);

    // line_mem[0] holds the oldest row, line_mem[K-2] the previous row.
    logic signed [DW-1:0] line_mem [K-1][IMG_W];
    logic signed [DW-1:0] tap_c    [K];
    logic signed [DW-1:0] win_q    [K][K];
    logic signed [DW-1:0] win_d    [K][K];

    // New right-hand column: the stored rows at this column plus the new pixel.
    always_comb begin
        for (int unsigned r = 0; r < K - 1; r++) begin
            tap_c[r] = line_mem[r][col_i];
        end
        tap_c[K-1] = pix_i;
    end

    // Each row shifts up by one line memory; no reset, stale data is never
    // inside a window that is flagged valid.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int unsigned r = 0; r < K - 2; r++) begin
                line_mem[r][col_i] <= line_mem[r+1][col_i];
            end
            line_mem[K-2][col_i] <= pix_i;
        end
    end

    // Window shift: every column moves left, taps enter on the right.
    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = tap_c[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '{default: '0};
        end else begin
            win_q <= win_d;
        end
    end

    // Flatten to row-major output order.
    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_o[r*K+c] = win_q[r][c];
            end
        end
    end

endmodule

// File: rtl/conv2_buf.sv
// conv2 input line buffer: turns a 3-channel raster pixel stream into 5x5
// windows per channel, one window per cycle, only where the window lies
// fully inside a single row band of a single frame.
// Ports: clk, rst (sync, active-high), bus (conv2_buf_if.slave: valid_in,
// data_in1..3 in; data_outC_0..24 and valid_out_buf out, all registered).
module conv2_buf
    import conv2_buf_pkg::*;
#(
    parameter int unsigned IMG_W = CNN_IMG_W,
    parameter int unsigned IMG_H = CNN_IMG_H,
    parameter int unsigned K     = CNN_K,
    parameter int unsigned DW    = CNN_DW
) (
    input  logic        clk,
    input  logic        rst,
    conv2_buf_if.slave  bus
);

    localparam int unsigned COL_W = idx_w(IMG_W);
    localparam int unsigned ROW_W = idx_w(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;
    logic             shift_en_c;

    logic signed [DW-1:0] win1_c [K*K];
    logic signed [DW-1:0] win2_c [K*K];
    logic signed [DW-1:0] win3_c [K*K];

    // Reset wins over a pixel presented in the same cycle.
    assign shift_en_c = bus.valid_in & ~rst;

    // Raster counters and window-valid decision for the pixel being accepted.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        if (bus.valid_in) begin
            valid_d = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    conv2_buf_ch #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_ch1 (
        .clk(clk), .rst(rst), .shift_en(shift_en_c), .col_i(col_q),
        .pix_i(bus.data_in1), .win_o(win1_c)
    );

    conv2_buf_ch #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_ch2 (
        .clk(clk), .rst(rst), .shift_en(shift_en_c), .col_i(col_q),
        .pix_i(bus.data_in2), .win_o(win2_c)
    );

    conv2_buf_ch #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_ch3 (
        .clk(clk), .rst(rst), .shift_en(shift_en_c), .col_i(col_q),
        .pix_i(bus.data_in3), .win_o(win3_c)
    );

    assign bus.valid_out_buf = valid_q;

    assign bus.data_out1_0  = win1_c[0];
    assign bus.data_out1_1  = win1_c[1];
    assign bus.data_out1_2  = win1_c[2];
    assign bus.data_out1_3  = win1_c[3];
    assign bus.data_out1_4  = win1_c[4];
    assign bus.data_out1_5  = win1_c[5];
    assign bus.data_out1_6  = win1_c[6];
    assign bus.data_out1_7  = win1_c[7];
    assign bus.data_out1_8  = win1_c[8];
    assign bus.data_out1_9  = win1_c[9];
    assign bus.data_out1_10 = win1_c[10];
    assign bus.data_out1_11 = win1_c[11];
    assign bus.data_out1_12 = win1_c[12];
    assign bus.data_out1_13 = win1_c[13];
    assign bus.data_out1_14 = win1_c[14];
    assign bus.data_out1_15 = win1_c[15];
    assign bus.data_out1_16 = win1_c[16];
    assign bus.data_out1_17 = win1_c[17];
    assign bus.data_out1_18 = win1_c[18];
    assign bus.data_out1_19 = win1_c[19];
    assign bus.data_out1_20 = win1_c[20];
    assign bus.data_out1_21 = win1_c[21];
    assign bus.data_out1_22 = win1_c[22];
    assign bus.data_out1_23 = win1_c[23];
    assign bus.data_out1_24 = win1_c[24];

    assign bus.data_out2_0  = win2_c[0];
    assign bus.data_out2_1  = win2_c[1];
    assign bus.data_out2_2  = win2_c[2];
    assign bus.data_out2_3  = win2_c[3];
    assign bus.data_out2_4  = win2_c[4];
    assign bus.data_out2_5  = win2_c[5];
    assign bus.data_out2_6  = win2_c[6];
    assign bus.data_out2_7  = win2_c[7];
    assign bus.data_out2_8  = win2_c[8];
    assign bus.data_out2_9  = win2_c[9];
    assign bus.data_out2_10 = win2_c[10];
    assign bus.data_out2_11 = win2_c[11];
    assign bus.data_out2_12 = win2_c[12];
    assign bus.data_out2_13 = win2_c[13];
    assign bus.data_out2_14 = win2_c[14];
    assign bus.data_out2_15 = win2_c[15];
    assign bus.data_out2_16 = win2_c[16];
    assign bus.data_out2_17 = win2_c[17];
    assign bus.data_out2_18 = win2_c[18];
    assign bus.data_out2_19 = win2_c[19];
    assign bus.data_out2_20 = win2_c[20];
    assign bus.data_out2_21 = win2_c[21];
    assign bus.data_out2_22 = win2_c[22];
    assign bus.data_out2_23 = win2_c[23];
    assign bus.data_out2_24 = win2_c[24];

    assign bus.data_out3_0  = win3_c[0];
    assign bus.data_out3_1  = win3_c[1];
    assign bus.data_out3_2  = win3_c[2];
    assign bus.data_out3_3  = win3_c[3];
    assign bus.data_out3_4  = win3_c[4];
    assign bus.data_out3_5  = win3_c[5];
    assign bus.data_out3_6  = win3_c[6];
    assign bus.data_out3_7  = win3_c[7];
    assign bus.data_out3_8  = win3_c[8];
    assign bus.data_out3_9  = win3_c[9];
    assign bus.data_out3_10 = win3_c[10];
    assign bus.data_out3_11 = win3_c[11];
    assign bus.data_out3_12 = win3_c[12];
    assign bus.data_out3_13 = win3_c[13];
    assign bus.data_out3_14 = win3_c[14];
    assign bus.data_out3_15 = win3_c[15];
    assign bus.data_out3_16 = win3_c[16];
    assign bus.data_out3_17 = win3_c[17];
    assign bus.data_out3_18 = win3_c[18];
    assign bus.data_out3_19 = win3_c[19];
    assign bus.data_out3_20 = win3_c[20];
    assign bus.data_out3_21 = win3_c[21];
    assign bus.data_out3_22 = win3_c[22];
    assign bus.data_out3_23 = win3_c[23];
    assign bus.data_out3_24 = win3_c[24];

endmodule

// File: tb/tb_conv2_buf.sv
// Self-checking bench for conv2_buf: directed ramp/extreme/reset frames and
// random frames, checked against a frame-array reference model.
module tb_conv2_buf;
    import conv2_buf_pkg::*;

    localparam int W = 12;
    localparam int H = 12;

    typedef logic signed [11:0] tpix_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv2_buf_if #(.DW(12)) bus ();

    conv2_buf #(.IMG_W(12), .IMG_H(12), .K(5), .DW(12)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    tpix_t o1 [25];
    tpix_t o2 [25];
    tpix_t o3 [25];

    assign o1[0]  = bus.data_out1_0;   assign o1[1]  = bus.data_out1_1;   assign o1[2]  = bus.data_out1_2;
    assign o1[3]  = bus.data_out1_3;   assign o1[4]  = bus.data_out1_4;   assign o1[5]  = bus.data_out1_5;
    assign o1[6]  = bus.data_out1_6;   assign o1[7]  = bus.data_out1_7;   assign o1[8]  = bus.data_out1_8;
    assign o1[9]  = bus.data_out1_9;   assign o1[10] = bus.data_out1_10;  assign o1[11] = bus.data_out1_11;
    assign o1[12] = bus.data_out1_12;  assign o1[13] = bus.data_out1_13;  assign o1[14] = bus.data_out1_14;
    assign o1[15] = bus.data_out1_15;  assign o1[16] = bus.data_out1_16;  assign o1[17] = bus.data_out1_17;
    assign o1[18] = bus.data_out1_18;  assign o1[19] = bus.data_out1_19;  assign o1[20] = bus.data_out1_20;
    assign o1[21] = bus.data_out1_21;  assign o1[22] = bus.data_out1_22;  assign o1[23] = bus.data_out1_23;
    assign o1[24] = bus.data_out1_24;
    assign o2[0]  = bus.data_out2_0;   assign o2[1]  = bus.data_out2_1;   assign o2[2]  = bus.data_out2_2;
    assign o2[3]  = bus.data_out2_3;   assign o2[4]  = bus.data_out2_4;   assign o2[5]  = bus.data_out2_5;
    assign o2[6]  = bus.data_out2_6;   assign o2[7]  = bus.data_out2_7;   assign o2[8]  = bus.data_out2_8;
    assign o2[9]  = bus.data_out2_9;   assign o2[10] = bus.data_out2_10;  assign o2[11] = bus.data_out2_11;
    assign o2[12] = bus.data_out2_12;  assign o2[13] = bus.data_out2_13;  assign o2[14] = bus.data_out2_14;
    assign o2[15] = bus.data_out2_15;  assign o2[16] = bus.data_out2_16;  assign o2[17] = bus.data_out2_17;
    assign o2[18] = bus.data_out2_18;  assign o2[19] = bus.data_out2_19;  assign o2[20] = bus.data_out2_20;
    assign o2[21] = bus.data_out2_21;  assign o2[22] = bus.data_out2_22;  assign o2[23] = bus.data_out2_23;
    assign o2[24] = bus.data_out2_24;
    assign o3[0]  = bus.data_out3_0;   assign o3[1]  = bus.data_out3_1;   assign o3[2]  = bus.data_out3_2;
    assign o3[3]  = bus.data_out3_3;   assign o3[4]  = bus.data_out3_4;   assign o3[5]  = bus.data_out3_5;
    assign o3[6]  = bus.data_out3_6;   assign o3[7]  = bus.data_out3_7;   assign o3[8]  = bus.data_out3_8;
    assign o3[9]  = bus.data_out3_9;   assign o3[10] = bus.data_out3_10;  assign o3[11] = bus.data_out3_11;
    assign o3[12] = bus.data_out3_12;  assign o3[13] = bus.data_out3_13;  assign o3[14] = bus.data_out3_14;
    assign o3[15] = bus.data_out3_15;  assign o3[16] = bus.data_out3_16;  assign o3[17] = bus.data_out3_17;
    assign o3[18] = bus.data_out3_18;  assign o3[19] = bus.data_out3_19;  assign o3[20] = bus.data_out3_20;
    assign o3[21] = bus.data_out3_21;  assign o3[22] = bus.data_out3_22;  assign o3[23] = bus.data_out3_23;
    assign o3[24] = bus.data_out3_24;

    // Reference model: current frame image per channel and raster position.
    tpix_t f1 [H][W];
    tpix_t f2 [H][W];
    tpix_t f3 [H][W];
    tpix_t e1 [25];
    tpix_t e2 [25];
    tpix_t e3 [25];
    bit    known;
    bit    exp_valid;
    int    mrow, mcol;
    int    n_cmp, n_err;
    int    pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_win(input string tag);
        for (int i = 0; i < 25; i++) begin
            chk($sformatf("%s_out1_%0d", tag, i), 32'(o1[i]), 32'(e1[i]));
            chk($sformatf("%s_out2_%0d", tag, i), 32'(o2[i]), 32'(e2[i]));
            chk($sformatf("%s_out3_%0d", tag, i), 32'(o3[i]), 32'(e3[i]));
        end
    endtask

    // Model of one accepted pixel: store it, and if a full 5x5 block ending
    // here lies inside the frame, that block is the expected window.
    task automatic model_pixel(input tpix_t a, input tpix_t b, input tpix_t c);
        f1[mrow][mcol] = a;
        f2[mrow][mcol] = b;
        f3[mrow][mcol] = c;
        exp_valid = (mrow >= 4) && (mcol >= 4);
        if (exp_valid) begin
            for (int wr = 0; wr < 5; wr++) begin
                for (int wc = 0; wc < 5; wc++) begin
                    e1[wr*5+wc] = f1[mrow-4+wr][mcol-4+wc];
                    e2[wr*5+wc] = f2[mrow-4+wr][mcol-4+wc];
                    e3[wr*5+wc] = f3[mrow-4+wr][mcol-4+wc];
                end
            end
            known = 1'b1;
        end else begin
            known = 1'b0;
        end
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic cycle(input bit v, input tpix_t a, input tpix_t b, input tpix_t c);
        rst          = 1'b0;
        bus.valid_in = v;
        bus.data_in1 = a;
        bus.data_in2 = b;
        bus.data_in3 = c;
        @(posedge clk);
        if (v) model_pixel(a, b, c);
        else   exp_valid = 1'b0;
        #1;
        chk("valid_out_buf", 32'(bus.valid_out_buf), 32'(exp_valid));
        if (bus.valid_out_buf === 1'b1) pulses++;
        if (known) check_win("win");
    endtask

    task automatic do_reset(input bit v);
        rst          = 1'b1;
        bus.valid_in = v;
        bus.data_in1 = tpix_t'($urandom);
        bus.data_in2 = tpix_t'($urandom);
        bus.data_in3 = tpix_t'($urandom);
        @(posedge clk);
        mrow = 0;
        mcol = 0;
        exp_valid = 1'b0;
        known = 1'b1;
        for (int i = 0; i < 25; i++) begin
            e1[i] = '0; e2[i] = '0; e3[i] = '0;
        end
        #1;
        chk("rst_valid_out_buf", 32'(bus.valid_out_buf), 32'(exp_valid));
        check_win("rst");
        rst = 1'b0;
    endtask

    // mode 0: ramp (p+off, -(p+off), 5); mode 1: data_in2 alternates -2048/+2047.
    task automatic frame(input int mode, input int off, input bit gaps, input int npix);
        tpix_t a, b, c;
        int    p;
        for (int k = 0; k < npix; k++) begin
            p = k + off;
            if (mode == 0) begin
                a = tpix_t'(p); b = tpix_t'(-p); c = tpix_t'(5);
            end else begin
                a = tpix_t'(p); b = (k % 2 == 1) ? tpix_t'(2047) : tpix_t'(-2048); c = '0;
            end
            if (gaps) cycle(1'b0, tpix_t'($urandom), tpix_t'($urandom), tpix_t'($urandom));
            cycle(1'b1, a, b, c);
            if (mode == 0 && k == 52) begin
                chk("first_valid", 32'(bus.valid_out_buf), 32'd1);
                chk("first_out1_0",  32'(o1[0]),  32'(tpix_t'(off)));
                chk("first_out1_4",  32'(o1[4]),  32'(tpix_t'(off + 4)));
                chk("first_out1_20", 32'(o1[20]), 32'(tpix_t'(off + 48)));
                chk("first_out1_24", 32'(o1[24]), 32'(tpix_t'(off + 52)));
                chk("first_out2_24", 32'(o2[24]), 32'(tpix_t'(-(off + 52))));
                chk("first_out3_0",  32'(o3[0]),  32'(tpix_t'(5)));
                chk("first_out3_24", 32'(o3[24]), 32'(tpix_t'(5)));
            end
            if (mode == 0 && k == 60) chk("no_pulse_col0", 32'(bus.valid_out_buf), 32'd0);
            if (mode == 0 && k == 143) begin
                chk("last_out1_0",  32'(o1[0]),  32'(tpix_t'(off + 91)));
                chk("last_out1_24", 32'(o1[24]), 32'(tpix_t'(off + 143)));
            end
            if (mode == 1 && k == 52) chk("ext_neg", 32'(o2[24]), 32'(tpix_t'(12'h800)));
            if (mode == 1 && k == 53) chk("ext_pos", 32'(o2[24]), 32'(tpix_t'(12'h7FF)));
        end
    endtask

    initial begin
        int acc;
        int guard;
        bit v;
        n_cmp = 0;
        n_err = 0;
        known = 1'b0;
        exp_valid = 1'b0;
        mrow = 0;
        mcol = 0;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in1 = '0;
        bus.data_in2 = '0;
        bus.data_in3 = '0;

        do_reset(1'b0);
        do_reset(1'b1);

        // Ramp frame, contiguous.
        pulses = 0;
        frame(0, 0, 1'b0, W * H);
        chk("ramp_pulses", 32'(pulses), 32'd64);

        // Idle cycles: outputs hold the last window, no pulse.
        for (int i = 0; i < 3; i++) cycle(1'b0, tpix_t'($urandom), tpix_t'($urandom), tpix_t'($urandom));

        // Ramp frame with valid_in low on alternate cycles.
        pulses = 0;
        frame(0, 0, 1'b1, W * H);
        chk("gap_pulses", 32'(pulses), 32'd64);

        // Reset after pixel 60: row 4 gave windows at cols 4..11 (8 pulses).
        pulses = 0;
        frame(0, 0, 1'b0, 61);
        chk("partial_pulses", 32'(pulses), 32'd8);
        do_reset(1'b1);
        pulses = 0;
        frame(0, 0, 1'b0, W * H);
        chk("post_rst_pulses", 32'(pulses), 32'd64);

        // Two back-to-back frames, second offset by 200.
        pulses = 0;
        frame(0, 0, 1'b0, W * H);
        frame(0, 200, 1'b0, W * H);
        chk("b2b_pulses", 32'(pulses), 32'd128);

        // Extreme channel-2 values.
        pulses = 0;
        frame(1, 0, 1'b0, W * H);
        chk("ext_pulses", 32'(pulses), 32'd64);

        // Random pixels, random valid_in, two frames.
        pulses = 0;
        acc = 0;
        guard = 0;
        while (acc < 2 * W * H && guard < 5000) begin
            v = ($urandom_range(0, 9) < 7);
            cycle(v, tpix_t'($urandom), tpix_t'($urandom), tpix_t'($urandom));
            if (v) acc++;
            guard++;
        end
        chk("rand_accepted", 32'(acc), 32'(2 * W * H));
        chk("rand_pulses", 32'(pulses), 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv2_buf.md
CONV2_BUF -- requirements
Module: conv2_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- IMG_W, 12, input feature-map width in pixels.
- IMG_H, 12, input feature-map height in pixels.
- K, 5, window size; the port list is fixed to K=5.
- DW, 12, signed pixel width.
REQ-002 The block has one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- valid_in, input, 1, the three data_in values are valid and accepted this cycle.
- data_in1, input, 12 signed, channel-1 pixel, raster order.
- data_in2, input, 12 signed, channel-2 pixel, same position as data_in1.
- data_in3, input, 12 signed, channel-3 pixel, same position as data_in1.
- data_out1_0 .. data_out1_24, output, 12 signed each, channel-1 5x5 window.
- data_out2_0 .. data_out2_24, output, 12 signed each, channel-2 5x5 window.
- data_out3_0 .. data_out3_24, output, 12 signed each, channel-3 5x5 window.
- valid_out_buf, output, 1, all 75 window outputs hold a complete new window this cycle.

Function
REQ-004 Each accepted pixel advances a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) in raster order.
- Column wraps to 0 and row increments after column IMG_W-1.
- Both counters wrap to 0 after the pixel at (IMG_H-1, IMG_W-1), which is the frame end; the next accepted pixel starts a new frame with no gap cycle required.
REQ-005 Per channel, four line buffers of IMG_W entries hold the previous four rows; a 5x5 register window shifts one column left per accepted pixel.
- The new right column is the last four rows at this column plus the incoming pixel.
REQ-006 Window mapping: data_outC_(r*5+c), with r=0 the oldest (top) row, r=4 the current row, c=0 the leftmost (oldest) column and c=4 the incoming pixel column.
REQ-007 valid_out_buf is asserted for exactly one cycle, in the cycle after an accepted pixel whose row>=K-1 and col>=K-1; the window outputs update in that same cycle.
- Result: (IMG_H-K+1)*(IMG_W-K+1) = 64 windows per frame.
REQ-008 Windows never straddle a row boundary or a frame boundary: no valid_out_buf for col<4 or row<4.
REQ-009 When valid_in=0, nothing shifts, the counters hold, valid_out_buf=0 in the next cycle, and the window outputs hold their last values.
REQ-010 Pixel values pass through bit-exact; no arithmetic, sign extension or saturation is applied.
REQ-011 There is no backpressure; the downstream calculator accepts one window per cycle unconditionally.

Reset
REQ-012 While rst=1 at a clock edge:
- Counters are set to 0.
- valid_out_buf is 0.
- All 75 window outputs are 0.
REQ-013 Line-buffer RAM contents need not be cleared; stale data is never exposed because of REQ-008.
REQ-014 A reset asserted mid-frame abandons the partial frame; the first pixel accepted after reset is (0,0).

Structure
REQ-015 IMG_W, IMG_H, K and DW default values live in the shared CNN parameter file, which is also used by the conv2 calculator blocks.
REQ-016 One sub-module, conv2_buf_ch, implements one channel (line buffers plus 5x5 window) and is instantiated three times.
- Counters and the valid logic stay in the top level and are shared by all three instances.

Verification
REQ-017 Ramp test. Stimulus: after reset, one frame with p=row*12+col, data_in1=p, data_in2=-p, data_in3=5.
- First valid_out_buf comes the cycle after pixel 52 is accepted.
- data_out1_0=0, data_out1_4=4, data_out1_20=48, data_out1_24=52, data_out2_24=-52, all data_out3_*=5.
REQ-018 Same frame, full count: exactly 64 valid_out_buf pulses.
- Last window: data_out1_0=91, data_out1_24=143.
- No pulse when col<4 (e.g. after pixel 60, which is row5,col0).
REQ-019 Same frame with valid_in deasserted on alternate cycles: identical 64 windows and values; valid_out_buf is never high in the cycle after a deasserted valid_in.
REQ-020 rst pulsed for one cycle after pixel 60 is accepted:
- The next cycle has valid_out_buf=0 and all outputs 0.
- A new ramp frame then yields its first window after pixel 52 with the values of REQ-017.
REQ-021 Two back-to-back frames, the second with p+200:
- 128 pulses total.
- The second frame's first window has data_out1_0=200, data_out1_24=252, with no window mixing the two frames.
REQ-022 Extremes: data_in2 of -2048 and +2047 appears unchanged in data_out2_24 (0x800 and 0x7FF).
